// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: alignment check, byte-enable/write-data lane steering,
// req/ack bus handshake and load data extraction with sign/zero extension.
module dm_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        stall,
   output logic        adel,
   output logic        ades,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t      state, state_nx;
   logic        c_we, c_sign;
   logic [2:0]  c_size;
   logic [1:0]  c_off;
   logic        is_word, is_half, is_byte, size_ok, aligned;
   logic [3:0]  be_nx;
   logic [31:0] wd_nx;
   logic [31:0] ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign is_word = (size == 3'b001);
   assign is_half = (size == 3'b010);
   assign is_byte = (size == 3'b100);
   assign size_ok = is_word | is_half | is_byte;
   assign stall   = req & ~done;

   always_comb begin
      aligned = 1'b1;
      if (is_word)      aligned = (addr[1:0] == 2'b00);
      else if (is_half) aligned = ~addr[0];
   end

   // Lane steering of the store data; loads reuse the same byte enables.
   always_comb begin
      be_nx = 4'b1111;
      wd_nx = wdata;
      if (is_half) begin
         be_nx = addr[1] ? 4'b1100 : 4'b0011;
         wd_nx = {wdata[15:0], wdata[15:0]};
      end else if (is_byte) begin
         be_nx = 4'b0001 << addr[1:0];
         wd_nx = {4{wdata[7:0]}};
      end
   end

   always_comb begin
      ld_byte = bus_rdata[{c_off, 3'b000} +: 8];
      ld_half = c_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ld_data = bus_rdata;
      if (c_size == 3'b100)      ld_data = {{24{c_sign & ld_byte[7]}}, ld_byte};
      else if (c_size == 3'b010) ld_data = {{16{c_sign & ld_half[15]}}, ld_half};
      if (c_we) ld_data = '0;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = (size_ok && aligned) ? ISSUE : DONE;
         ISSUE:   if (bus_ack) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_we      <= 1'b0;
         c_sign    <= 1'b0;
         c_size    <= 3'b000;
         c_off     <= 2'b00;
         done      <= 1'b0;
         adel      <= 1'b0;
         ades      <= 1'b0;
         rdata     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= 4'b0000;
         bus_wdata <= '0;
      end else begin
         done <= 1'b0;
         adel <= 1'b0;
         ades <= 1'b0;
         case (state)
            IDLE: if (req) begin
               c_we   <= we;
               c_sign <= sign;
               c_size <= size;
               c_off  <= addr[1:0];
               if (size_ok && aligned) begin
                  bus_req   <= 1'b1;
                  bus_we    <= we;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= be_nx;
                  bus_wdata <= wd_nx;
               end else begin
                  // Misaligned or null: complete at once, never touching the bus.
                  done  <= 1'b1;
                  adel  <= size_ok & ~we;
                  ades  <= size_ok & we;
                  rdata <= '0;
               end
            end
            ISSUE: if (bus_ack) begin
               bus_req <= 1'b0;
               bus_we  <= 1'b0;
               done    <= 1'b1;
               rdata   <= ld_data;
            end
            default: ;
         endcase
      end
   end

endmodule
